// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Divide-by-zero quotient is all ones at any width; replicate this bit.
  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so a negative difference always shows in the top bit.
  always_comb begin
    shifted  = {rem, next_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider, one quotient bit per cycle, with tag and cancel.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;  // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvs;
  logic             x_neg;
  logic             q_neg;
  logic [TAG_W-1:0] tag;

  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_raw;

  always_comb begin
    x_abs = (in_signed && in_x[WIDTH-1]) ? -in_x : in_x;
    y_abs = (in_signed && in_y[WIDTH-1]) ? -in_y : in_y;
    q_raw = {dvd[WIDTH-2:0], q_bit};
  end

  assign in_ready = (state == IDLE);

  div_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem),
    .divisor  (dvs),
    .next_bit (dvd[WIDTH-1]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      x_neg     <= 1'b0;
      q_neg     <= 1'b0;
      tag       <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dbz   <= 1'b0;
      out_tag   <= '0;
    end else if (cancel) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            tag   <= in_tag;
            x_neg <= in_signed & in_x[WIDTH-1];
            q_neg <= in_signed & (in_x[WIDTH-1] ^ in_y[WIDTH-1]);
            dvd   <= x_abs;
            dvs   <= y_abs;
            rem   <= '0;
            cnt   <= CNT_W'(WIDTH - 1);
            if (in_y == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_q     <= {WIDTH{DBZ_Q_FILL}};
              out_r     <= in_x;
              out_dbz   <= 1'b1;
              out_tag   <= in_tag;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          dvd <= q_raw;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_q     <= q_neg ? -q_raw : q_raw;
            out_r     <= x_neg ? -rem_next : rem_next;
            out_dbz   <= 1'b0;
            out_tag   <= tag;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (WIDTH=32, TAG_W=4).
module tb_div_iter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 4;

  logic             div_clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_signed = 1'b0;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             cancel = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dbz;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  always #5 div_clk = ~div_clk;

  div_iter #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .div_clk   (div_clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dbz   (out_dbz),
    .out_tag   (out_tag)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Present one request; returns #1 after the accept edge with inputs scrambled.
  task automatic start_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] t);
    @(negedge div_clk);
    in_signed = s;
    in_x      = x;
    in_y      = y;
    in_tag    = t;
    in_valid  = 1'b1;
    @(posedge div_clk);
    #1;
    in_valid  = 1'b0;
    in_signed = ~s;
    in_x      = 32'hA5A5_A5A5;
    in_y      = 32'h0000_0000;
    in_tag    = ~t;
  endtask

  // Edges counted with the accept edge as edge 1; bounded.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge div_clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input logic [3:0] t, input logic [31:0] eq,
                        input logic [31:0] er, input logic edbz, input int elat);
    int lat;
    start_op(s, x, y, t);
    wait_result(lat);
    check({name, ".lat"}, 32'(lat), 32'(elat));
    check({name, ".q"}, out_q, eq);
    check({name, ".r"}, out_r, er);
    check({name, ".dbz"}, 32'(out_dbz), 32'(edbz));
    check({name, ".tag"}, 32'(out_tag), 32'(t));
    @(posedge div_clk);
    #1;
    check({name, ".idle"}, 32'(in_ready), 32'd1);
    check({name, ".vld_clr"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    // Reset state
    #2;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_q", out_q, 32'd0);
    check("rst.out_r", out_r, 32'd0);
    check("rst.out_dbz", 32'(out_dbz), 32'd0);
    check("rst.out_tag", 32'(out_tag), 32'd0);
    @(negedge div_clk);
    @(negedge div_clk);
    resetn = 1'b1;
    @(posedge div_clk);
    #1;
    check("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Main function
    run_op("u7_2", 1'b0, 32'd7, 32'd2, 4'd3, 32'd3, 32'd1, 1'b0, 33);
    run_op("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 4'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_op("u5_0", 1'b0, 32'd5, 32'd0, 4'd7, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_op("s5_0", 1'b1, 32'd5, 32'd0, 4'd8, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_op("sm5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    run_op("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd10, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_op("umax_2", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 4'd11, 32'd1, 32'h7FFF_FFFF, 1'b0, 33);
    run_op("s100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 4'd12, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    run_op("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 4'd13, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run_op("u_big", 1'b0, 32'hFFFF_FF9C, 32'd7, 4'd14, 32'h2492_4916, 32'd2, 1'b0, 33);

    // Back-pressure: results held stable, no new accepts
    out_ready = 1'b0;
    start_op(1'b0, 32'd1000, 32'd3, 4'd2);
    wait_result(lat);
    check("bp.lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge div_clk);
      #1;
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.q", out_q, 32'd333);
      check("bp.r", out_r, 32'd1);
      check("bp.tag", 32'(out_tag), 32'd2);
      check("bp.in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge div_clk);
    out_ready = 1'b1;
    @(posedge div_clk);
    #1;
    check("bp.release_idle", 32'(in_ready), 32'd1);
    check("bp.release_vld", 32'(out_valid), 32'd0);

    // Cancel mid-CALC
    start_op(1'b0, 32'd1000, 32'd3, 4'd4);
    repeat (10) @(posedge div_clk);
    #1;
    check("cancel.busy", 32'(in_ready), 32'd0);
    @(negedge div_clk);
    cancel = 1'b1;
    @(posedge div_clk);
    #1;
    cancel = 1'b0;
    check("cancel.idle", 32'(in_ready), 32'd1);
    check("cancel.vld", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge div_clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("cancel.no_result", 32'(seen), 32'd0);

    // Accept coincident with cancel is dropped
    @(negedge div_clk);
    in_valid = 1'b1;
    in_x     = 32'd9;
    in_y     = 32'd0;
    cancel   = 1'b1;
    @(posedge div_clk);
    #1;
    in_valid = 1'b0;
    cancel   = 1'b0;
    check("cancel_acc.idle", 32'(in_ready), 32'd1);
    check("cancel_acc.vld", 32'(out_valid), 32'd0);
    run_op("after_cancel", 1'b0, 32'd100, 32'd7, 4'd1, 32'd14, 32'd2, 1'b0, 33);

    // Asynchronous reset mid-CALC, between edges
    start_op(1'b0, 32'd1000, 32'd3, 4'd4);
    repeat (5) @(posedge div_clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_calc.vld", 32'(out_valid), 32'd0);
    check("arst_calc.ready", 32'(in_ready), 32'd1);
    @(negedge div_clk);
    resetn = 1'b1;

    // Asynchronous reset mid-DONE
    out_ready = 1'b0;
    start_op(1'b0, 32'd1000, 32'd3, 4'd15);
    wait_result(lat);
    check("arst_done.pre_vld", 32'(out_valid), 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_done.vld", 32'(out_valid), 32'd0);
    check("arst_done.ready", 32'(in_ready), 32'd1);
    check("arst_done.q", out_q, 32'd0);
    check("arst_done.r", out_r, 32'd0);
    check("arst_done.tag", 32'(out_tag), 32'd0);
    @(negedge div_clk);
    resetn    = 1'b1;
    out_ready = 1'b1;

    run_op("final", 1'b0, 32'd7, 32'd2, 4'd3, 32'd3, 32'd1, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
